// File: rtl/rect_fill.sv
// ============================================================================
//  Module   : rect_fill
//  Purpose  : Rectangle fill engine; emits one pixel write per accepted cycle
//             in raster order. Define RECT_FILL_CLIP_EN to clamp to the screen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rect_fill #(
    parameter int WIDTH   = 11,
    parameter int CWIDTH  = 24,
    parameter int HACTIVE = 1280,
    parameter int VACTIVE = 640
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  x0,
    input  logic [WIDTH-1:0]  y0,
    input  logic [WIDTH-1:0]  x1,
    input  logic [WIDTH-1:0]  y1,
    input  logic [CWIDTH-1:0] color,
    input  logic              ready,
    output logic [WIDTH-1:0]  x,
    output logic [WIDTH-1:0]  y,
    output logic [CWIDTH-1:0] pix_color,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef RECT_FILL_CLIP_EN
    localparam bit c_CLIP_EN = 1'b1;
`else
    localparam bit c_CLIP_EN = 1'b0;
`endif
    localparam logic [WIDTH-1:0] c_XMAX = WIDTH'(HACTIVE - 1);
    localparam logic [WIDTH-1:0] c_YMAX = WIDTH'(VACTIVE - 1);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_x0, r_x1, r_y1;
    logic [WIDTH-1:0]   r_x, r_y, w_x_nxt, w_y_nxt;
    logic [CWIDTH-1:0]  r_color;
    logic               r_wr_en, r_busy, r_done;
    logic               w_load;
    logic [WIDTH-1:0]   w_x1_eff, w_y1_eff;
    logic               w_empty;

    // Clamping x1/y1 alone also empties any rectangle whose x0/y0 is off-screen.
    assign w_x1_eff = (c_CLIP_EN && (x1 > c_XMAX)) ? c_XMAX : x1;
    assign w_y1_eff = (c_CLIP_EN && (y1 > c_YMAX)) ? c_YMAX : y1;
    assign w_empty  = (x0 > w_x1_eff) || (y0 > w_y1_eff);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (w_empty) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FILL;
                        w_x_nxt     = x0;
                        w_y_nxt     = y0;
                    end
                end
            end
            S_FILL: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (ready) begin
                    // Compare before increment so x1/y1 at all-ones never wrap.
                    if (r_x < r_x1) begin
                        w_x_nxt = r_x + 1'b1;
                    end else if (r_y < r_y1) begin
                        w_x_nxt = r_x0;
                        w_y_nxt = r_y + 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            if (w_load) begin
                r_x0    <= x0;
                r_x1    <= w_x1_eff;
                r_y1    <= w_y1_eff;
                r_color <= color;
            end
            r_wr_en <= (w_state_nxt == S_FILL);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign pix_color = r_color;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rect_fill.sv
// ============================================================================
//  Module   : tb_rect_fill
//  Purpose  : Directed self-checking bench for rect_fill on a 4x4 screen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rect_fill;

    localparam int WIDTH  = 4;
    localparam int CWIDTH = 8;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  x0, y0, x1, y1;
    logic [CWIDTH-1:0] color;
    logic              ready;
    logic [WIDTH-1:0]  x, y;
    logic [CWIDTH-1:0] pix_color;
    logic              wr_en, busy, done;

    int checks   = 0;
    int failures = 0;
    int accepted;

    rect_fill #(
        .WIDTH   (WIDTH),
        .CWIDTH  (CWIDTH),
        .HACTIVE (4),
        .VACTIVE (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color),
        .ready     (ready),
        .x         (x),
        .y         (y),
        .pix_color (pix_color),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input int ax0, input int ay0, input int ax1, input int ay1,
                               input logic [CWIDTH-1:0] col);
        x0    = WIDTH'(ax0);
        y0    = WIDTH'(ay0);
        x1    = WIDTH'(ax1);
        y1    = WIDTH'(ay1);
        color = col;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Expects a full raster walk of (ax0,ay0)-(ex1,ey1) with ready held high.
    task automatic fill_check(input string tag, input int ax0, input int ay0,
                              input int ax1, input int ay1, input int ex1, input int ey1,
                              input logic [CWIDTH-1:0] col, input bit poke);
        int n;
        n     = 0;
        ready = 1'b1;
        drive_start(ax0, ay0, ax1, ay1, col);
        color = ~col;
        for (int yy = ay0; yy <= ey1; yy++) begin
            for (int xx = ax0; xx <= ex1; xx++) begin
                check({tag, ".wr_en"}, 32'(wr_en), 32'd1);
                check({tag, ".x"}, 32'(x), 32'(xx));
                check({tag, ".y"}, 32'(y), 32'(yy));
                check({tag, ".color"}, 32'(pix_color), 32'(col));
                if (poke && n == 1) begin
                    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
                    start = 1'b1;
                end
                step();
                start = 1'b0;
                n++;
            end
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".done_wr"}, 32'(wr_en), 32'd0);
        step();
        check({tag, ".done_clr"}, 32'(done), 32'd0);
        check({tag, ".busy_clr"}, 32'(busy), 32'd0);
    endtask

    task automatic empty_check(input string tag, input int ax0, input int ay0,
                               input int ax1, input int ay1);
        drive_start(ax0, ay0, ax1, ay1, 8'h3C);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".wr_en"}, 32'(wr_en), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        step();
        check({tag, ".done_clr"}, 32'(done), 32'd0);
        check({tag, ".busy_clr"}, 32'(busy), 32'd0);
        check({tag, ".wr_idle"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        color   = '0;
        #1;
        check("rst.x", 32'(x), 32'd0);
        check("rst.y", 32'(y), 32'd0);
        check("rst.pix", 32'(pix_color), 32'd0);
        check("rst.wr_en", 32'(wr_en), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        fill_check("clear", 0, 0, 3, 3, 3, 3, 8'hA5, 1'b0);
        fill_check("sub", 1, 2, 2, 3, 2, 3, 8'h5A, 1'b0);
        fill_check("busy_start", 0, 1, 2, 2, 2, 2, 8'h77, 1'b1);

        // Backpressure: ready 1,0,0,1 over (0,0)-(1,0).
        accepted = 0;
        ready    = 1'b1;
        drive_start(0, 0, 1, 0, 8'h11);
        check("bp.x0", 32'(x), 32'd0);
        accepted += int'(wr_en && ready);
        step();
        ready = 1'b0;
        check("bp.x1", 32'(x), 32'd1);
        accepted += int'(wr_en && ready);
        step();
        check("bp.hold1_x", 32'(x), 32'd1);
        check("bp.hold1_y", 32'(y), 32'd0);
        check("bp.hold1_wr", 32'(wr_en), 32'd1);
        accepted += int'(wr_en && ready);
        step();
        check("bp.hold2_x", 32'(x), 32'd1);
        check("bp.hold2_wr", 32'(wr_en), 32'd1);
        ready = 1'b1;
        accepted += int'(wr_en && ready);
        step();
        check("bp.done", 32'(done), 32'd1);
        check("bp.accepted", 32'(accepted), 32'd2);
        step();
        check("bp.idle", 32'(busy), 32'd0);

        // Abort after three completed writes of a 4x4 fill.
        drive_start(0, 0, 3, 3, 8'h22);
        step();
        step();
        step();
        check("abort.x_before", 32'(x), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort.wr_en", 32'(wr_en), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        step();
        check("abort.done_late", 32'(done), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort.idle_noeffect", 32'(busy), 32'd0);
        fill_check("single", 0, 0, 0, 0, 0, 0, 8'h33, 1'b0);

        empty_check("empty_x", 3, 0, 1, 2);
        empty_check("empty_y", 0, 3, 2, 1);

`ifdef RECT_FILL_CLIP_EN
        fill_check("clip", 2, 2, 9, 9, 3, 3, 8'h44, 1'b0);
        empty_check("clip_off", 5, 0, 6, 0);
        empty_check("clip_max", 14, 0, 15, 0);
`else
        fill_check("noclip", 2, 2, 9, 9, 9, 9, 8'h44, 1'b0);
        fill_check("noclip_off", 5, 0, 6, 0, 6, 0, 8'h55, 1'b0);
        fill_check("nowrap", 14, 0, 15, 0, 15, 0, 8'h66, 1'b0);
`endif

        // Asynchronous reset in the middle of a fill.
        ready = 1'b1;
        drive_start(1, 1, 3, 3, 8'h99);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.x", 32'(x), 32'd0);
        check("arst.y", 32'(y), 32'd0);
        check("arst.pix", 32'(pix_color), 32'd0);
        check("arst.wr_en", 32'(wr_en), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("arst.after_done", 32'(done), 32'd0);
        check("arst.after_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
